// File: rtl/run_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared definitions for the run controller: FSM state
//               encoding, the default exit-mailbox address and a helper
//               that sizes the hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // Run controller states; 2-bit encoding is fixed so the bench can decode it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    // Default address of the exit mailbox the program writes to finish
    localparam logic [31:0] c_tohost_addr_default = 32'h0000_0100;

    // Width of the externally visible run-cycle counter
    localparam int c_cycle_count_w = 32;

    // Bits needed to count 0 .. cycles-1 (never less than one bit)
    function automatic int hold_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage : run_ctrl_pkg
`default_nettype wire

// File: rtl/run_ctrl_cycle_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cycle_counter
// Description : Registered up-counter with synchronous clear-to-zero load
//               and count enable. Load has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Clear on reset or load, otherwise advance by one when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : cycle_counter
`default_nettype wire

// File: rtl/run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run controller placed beside a single-cycle core. Holds the
//               core in reset for RST_CYCLES after a start pulse, lets it run
//               while counting cycles, and stops it on an exit-mailbox write
//               or when the cycle budget is used up. Result status is held
//               until the next start.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                RST_CYCLES  = 4,
    parameter int                MAX_CYCLES  = 1024,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(c_tohost_addr_default)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic                       core_rst,
    output logic                       running,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [DATA_W-2:0]          exit_code,
    output logic [c_cycle_count_w-1:0] cycle_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                         c_hold_w    = hold_cnt_width(RST_CYCLES);
    localparam logic [c_hold_w-1:0]        c_hold_last = c_hold_w'(RST_CYCLES - 1);
    localparam logic [c_cycle_count_w-1:0] c_run_last  = c_cycle_count_w'(MAX_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    run_state_t         r_state;
    logic               r_core_rst;
    logic               r_running;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic [DATA_W-2:0]  r_exit_code;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic                       w_in_hold;
    logic                       w_in_run;
    logic                       w_start_accept;
    logic                       w_hold_last;
    logic                       w_exit_write;
    logic                       w_budget_out;
    logic [DATA_W-2:0]          w_exit_value;
    logic                       w_hold_load;
    logic                       w_hold_en;
    logic                       w_run_load;
    logic                       w_run_en;
    logic [c_hold_w-1:0]        w_hold_count;
    logic [c_cycle_count_w-1:0] w_run_count;

    assign w_in_hold      = (r_state == ST_HOLD);
    assign w_in_run       = (r_state == ST_RUN);

    // start only launches from IDLE or DONE; a start mid-run is dropped
    assign w_start_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign w_hold_last    = w_in_hold && (w_hold_count == c_hold_last);

    // Bit 0 of the mailbox write is the "finished" flag; the rest is the code
    assign w_exit_write   = w_in_run && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign w_exit_value   = mem_wdata[DATA_W-1:1];

    assign w_budget_out   = w_in_run && (w_run_count == c_run_last);

    // Hold counter restarts at zero on every accepted start
    assign w_hold_load    = w_start_accept;
    assign w_hold_en      = w_in_hold;

    // Run counter clears on a new start (status clear) and on entry to RUN;
    // it freezes on the terminating cycle so the final count is reported
    assign w_run_load     = w_start_accept || w_hold_last;
    assign w_run_en       = w_in_run && !w_exit_write && !w_budget_out;

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    cycle_counter #(
        .WIDTH (c_hold_w)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (w_hold_load),
        .enable (w_hold_en),
        .count  (w_hold_count)
    );

    cycle_counter #(
        .WIDTH (c_cycle_count_w)
    ) u_run_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (w_run_load),
        .enable (w_run_en),
        .count  (w_run_count)
    );

    // ------------------------------------------------------------------------
    // Run-control state machine with registered status outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_core_rst  <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    // Release the core after exactly RST_CYCLES held cycles
                    if (w_hold_last) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b1;
                        r_running  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    // An exit write beats budget exhaustion in the same cycle
                    if (w_exit_write) begin
                        r_state     <= ST_DONE;
                        r_core_rst  <= 1'b0;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_exit_code <= w_exit_value;
                        r_pass      <= (w_exit_value == '0);
                        r_timeout   <= 1'b0;
                    end else if (w_budget_out) begin
                        r_state     <= ST_DONE;
                        r_core_rst  <= 1'b0;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_exit_code <= '0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // Relaunch: clear status, core stays frozen through HOLD
                    if (start) begin
                        r_state     <= ST_HOLD;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_exit_code <= '0;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_core_rst <= 1'b0;
                    r_running  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign core_rst    = r_core_rst;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign exit_code   = r_exit_code;
    assign cycle_count = w_run_count;

endmodule : run_ctrl
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4, number of cycles the core is held in reset after start (min 1).
REQ-002 Parameter MAX_CYCLES, default 1024, run-cycle budget before timeout (min 2).
REQ-003 Parameter ADDR_W, default 32, core data-memory address width.
REQ-004 Parameter DATA_W, default 32, core data-memory write-data width.
REQ-005 Parameter TOHOST_ADDR, default 32'h0000_0100, exit-mailbox address.
REQ-006 Port clk, input, 1, single clock; all logic on rising edge.
REQ-007 Port rst, input, 1, reset; synchronous and active-high.
REQ-008 Port start, input, 1, single-cycle pulse that launches a run.
REQ-009 Port mem_we, input, 1, core data-memory write enable.
REQ-010 Port mem_addr, input, ADDR_W, core data-memory write address.
REQ-011 Port mem_wdata, input, DATA_W, core data-memory write data.
REQ-012 Port core_rst, output, 1, active-low reset to the single-cycle core (0 = core held in reset).
REQ-013 Port running, output, 1, high while the core executes.
REQ-014 Port done, output, 1, high while the run has finished.
REQ-015 Port pass, output, 1, valid when done is high: exit code was zero.
REQ-016 Port timeout, output, 1, valid when done is high: the run ended on budget exhaustion.
REQ-017 Port exit_code, output, DATA_W-1, captured exit code.
REQ-018 Port cycle_count, output, 32, run cycles elapsed.

Function
REQ-019 FSM states are IDLE, HOLD, RUN and DONE.
REQ-020 IDLE -> HOLD on start; the hold counter loads 0.
REQ-021 In HOLD, core_rst=0 and the hold counter increments each cycle; HOLD -> RUN when the counter equals RST_CYCLES-1, giving exactly RST_CYCLES low cycles of core_rst.
REQ-022 On entry to RUN, cycle_count=0, core_rst=1 and running=1; cycle_count increments by 1 every RUN cycle.
REQ-023 An exit write is mem_we=1, mem_addr==TOHOST_ADDR and mem_wdata[0]=1 during RUN.
REQ-024 On an exit write: RUN -> DONE, exit_code<=mem_wdata[DATA_W-1:1], pass<=(exit_code==0), timeout<=0.
REQ-025 Writes to TOHOST_ADDR with mem_wdata[0]=0, and writes to any other address, are ignored.
REQ-026 In RUN, when cycle_count==MAX_CYCLES-1 with no exit write that cycle: RUN -> DONE, timeout<=1, pass<=0, exit_code<=0.
REQ-027 When an exit write and budget exhaustion occur in the same cycle, the exit write wins (REQ-024).
REQ-028 In DONE: core_rst=0 (core frozen), running=0, done=1, and cycle_count, pass, timeout and exit_code are held.
REQ-029 start in DONE -> HOLD and clears pass, timeout, exit_code and cycle_count.
REQ-030 start in HOLD or RUN is ignored.
REQ-031 mem_* inputs are ignored outside RUN.
REQ-032 All outputs are registered; done, pass and timeout assert one cycle after the terminating event.

Reset
REQ-033 rst=1 at a clock edge forces IDLE from any state, including mid-HOLD and mid-RUN.
REQ-034 Reset values are: core_rst=0, running=0, done=0, pass=0, timeout=0, exit_code=0, cycle_count=0, hold counter=0.
REQ-035 rst has priority over start in the same cycle.

Structure
REQ-036 The FSM state encoding and the TOHOST_ADDR default belong in a shared package used by run_ctrl and by the top-level testbench.
REQ-037 A sub-module cycle_counter (load, enable, count) is instantiated for both the hold counter and the run counter.
REQ-038 run_ctrl instantiates no processor logic; it connects beside SingleCycle_Top, driving its rst through core_rst.

Verification
REQ-039 rst 2 cycles, start pulse, RST_CYCLES=4 -> core_rst low for exactly 4 cycles, then running=1 and cycle_count=0.
REQ-040 In RUN, at cycle_count=10: mem_we=1, addr=0x100, wdata=0x1 -> next cycle done=1, pass=1, exit_code=0, cycle_count=10.
REQ-041 Write wdata=0x7 to 0x100 -> done=1, pass=0, exit_code=3; a prior write with wdata=0x6 to 0x100 causes no change.
REQ-042 MAX_CYCLES=16 with no exit write -> done=1, timeout=1, cycle_count=15; with the exit write in that same cycle -> timeout=0 and pass per wdata.
REQ-043 rst asserted during RUN -> next cycle all outputs at reset values; start during RUN is ignored.
REQ-044 start in DONE -> new HOLD, and the status outputs are cleared.
